ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the send side of the keyboard link, complementing the existing PS/2 scancode receiver.
- Sends one command byte to the keyboard, for example 0xED (set LEDs) plus its argument, or 0xFF (reset).
- Drives the open-drain ps2c/ps2d lines through active-high pull-low enables.
- Reports success, NACK or timeout to the keyboard control logic.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host link.
//   tx_state_e      - host transmitter state encoding
//   *_DEF           - default timing constants for a 25 MHz clock
//   TO_W/INH_W/IDX_W - counter widths of the transmitter
//   odd_parity()    - parity bit that makes the 9-bit data+parity frame odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_ACK      = 3'd3,
        ST_WAITIDLE = 3'd4
    } tx_state_e;

    localparam int INHIBIT_CYCLES_DEF = 2500;    // 100 us
    localparam int FILTER_CYCLES_DEF  = 8;
    localparam int TIMEOUT_CYCLES_DEF = 375000;  // 15 ms

    localparam int TO_W  = 19;
    localparam int INH_W = 12;
    localparam int IDX_W = 4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between keyboard control logic (master)
// and the PS/2 host transmitter (slave).
//   wr    - one-cycle request to send data
//   data  - command byte, captured on an accepted wr
//   busy  - transaction in progress
//   done  - one-cycle completion pulse
//   err   - valid with done: 1 = NACK or timeout
//   state - transmitter FSM state, for observation only
//
// Handshake: wr is accepted only on a cycle where busy is 0; an accepted wr
// raises busy on the following cycle. wr while busy is dropped, not queued.
// Every accepted wr produces exactly one done pulse (with busy already 0 in
// that same cycle), unless reset intervenes.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic       wr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       err;
    tx_state_e  state;

    modport master (output wr, data, input busy, done, err, state);
    modport slave  (input wr, data, output busy, done, err, state);

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one PS/2 pad input.
//   pixclk, rst_n - clock, async active-low reset
//   line_in       - raw pad value
//   line_sync     - 2-flop synchronised value
//   line_filt     - synchronised value after FILTER_CYCLES of stability
//   fall          - one-cycle pulse when line_filt goes 1 -> 0
// Lines idle high, so the flops reset to 1 to avoid a false edge after reset.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic pixclk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_sync,
    output logic line_filt,
    output logic fall
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            line_filt <= 1'b1;
            cnt       <= '0;
            fall      <= 1'b0;
        end else begin
            meta      <= line_in;
            line_sync <= meta;
            fall      <= 1'b0;
            // cnt counts consecutive samples that disagree with line_filt;
            // any agreeing sample restarts it, so short glitches vanish.
            if (line_sync == line_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                line_filt <= line_sync;
                cnt       <= '0;
                fall      <= line_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte
// (8 data bits LSB first, odd parity, stop) and reports ack/NACK/timeout.
//   pixclk, rst_n      - 25 MHz clock, async active-low reset
//   ps2c, ps2d         - PS/2 clock/data as read from the pads
//   ps2c_low, ps2d_low - 1 = pull the open-drain line low
//   host               - command handshake (wr/data in; busy/done/err out)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int FILTER_CYCLES  = FILTER_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                pixclk,
    input  logic                rst_n,
    input  logic                ps2c,
    input  logic                ps2d,
    output logic                ps2c_low,
    output logic                ps2d_low,
    ps2_host_tx_if.slave        host
);
    tx_state_e              state;
    logic [7:0]             data_q;
    logic [INH_W-1:0]       inh_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   err_pend;
    logic                   busy_q, done_q, err_q;
    logic                   c_filt, c_fall, c_sync_unused;
    logic                   d_meta, d_sync;
    logic                   progress, timed_out;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .pixclk    (pixclk),
        .rst_n     (rst_n),
        .line_in   (ps2c),
        .line_sync (c_sync_unused),
        .line_filt (c_filt),
        .fall      (c_fall)
    );

    // Data only needs synchronising: it is sampled on filtered clock edges.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // Any protocol progress in a timed state suppresses the timeout.
    always_comb begin
        progress = c_fall;
        if (state == ST_WAITIDLE) progress = c_fall || (c_filt && d_sync);
    end

    assign timed_out = (state == ST_SHIFT || state == ST_ACK || state == ST_WAITIDLE)
                       && (to_cnt == '0) && !progress;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            bit_idx  <= '0;
            err_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (timed_out) begin
                ps2c_low <= 1'b0;
                ps2d_low <= 1'b0;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
                busy_q   <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                if (state == ST_SHIFT || state == ST_ACK || state == ST_WAITIDLE) begin
                    if (c_fall)              to_cnt <= TO_W'(TIMEOUT_CYCLES);
                    else if (to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (host.wr) begin
                            data_q   <= host.data;
                            busy_q   <= 1'b1;
                            ps2c_low <= 1'b1;
                            inh_cnt  <= '0;
                            err_pend <= 1'b0;
                            state    <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        // Clock held low INHIBIT_CYCLES, then the start bit is
                        // asserted with clock still low, then clock released.
                        if (inh_cnt == INH_W'(INHIBIT_CYCLES)) begin
                            ps2c_low <= 1'b0;
                            bit_idx  <= '0;
                            to_cnt   <= TO_W'(TIMEOUT_CYCLES);
                            state    <= ST_SHIFT;
                        end else begin
                            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) ps2d_low <= 1'b1;
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (c_fall) begin
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx < IDX_W'(8)) begin
                                ps2d_low <= ~data_q[bit_idx[2:0]];
                            end else if (bit_idx == IDX_W'(8)) begin
                                ps2d_low <= ~odd_parity(data_q);
                            end else begin
                                ps2d_low <= 1'b0;   // stop bit: release data
                                state    <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (c_fall) begin
                            err_pend <= d_sync;     // device must hold data low
                            state    <= ST_WAITIDLE;
                        end
                    end
                    ST_WAITIDLE: begin
                        if (c_filt && d_sync) begin
                            done_q <= 1'b1;
                            err_q  <= err_pend;
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.err   = err_q;
    assign host.state = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 keyboard
// on the far end of the open-drain lines.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 100;
    localparam int FLT = 8;
    localparam int TO  = 1500;
    localparam int H   = 30;    // device half clock period, in pixclk cycles

    // ---------------- clock / reset ----------------
    logic pixclk;
    logic rst_n;
    int   cyc;

    initial begin
        pixclk = 1'b0;
        forever #20 pixclk = ~pixclk;
    end

    always @(posedge pixclk) cyc <= cyc + 1;

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- DUT and open-drain bus ----------------
    logic ps2c_low, ps2d_low;
    logic dev_c_low, dev_d_low;
    logic ps2c_w, ps2d_w;

    assign ps2c_w = ~(ps2c_low | dev_c_low);
    assign ps2d_w = ~(ps2d_low | dev_d_low);

    ps2_host_tx_if hif ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_CYCLES  (FLT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pixclk   (pixclk),
        .rst_n    (rst_n),
        .ps2c     (ps2c_w),
        .ps2d     (ps2d_w),
        .ps2c_low (ps2c_low),
        .ps2d_low (ps2d_low),
        .host     (hif)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [0:0] exp_q[$];   // expected err value of each pending done pulse
    logic       prev_done = 1'b0;
    logic       prev_d_low = 1'b0;
    logic [0:0] mon_e;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frame the device must see on its rising edges: {stop, parity, data}.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);   // makes the data+parity count odd
        return {1'b1, p, d};
    endfunction

    // Per-cycle compare process.
    always @(negedge pixclk) begin
        if (rst_n) begin
            if (hif.done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_err", hif.err, mon_e);
                end
                check("busy_at_done", hif.busy, 0);
                check("lines_at_done", {ps2c_low, ps2d_low}, 0);
                check("done_width", prev_done, 0);
            end else begin
                check("err_without_done", hif.err, 0);
            end
            // Data may only move while the clock line is low (start bit aside).
            if (hif.busy && !ps2c_low && !hif.done && ps2d_low !== prev_d_low)
                check("data_edge_clock_low", ps2c_w, 0);
        end
        prev_done  = hif.done;
        prev_d_low = ps2d_low;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int bound, output int t_done);
        int i;
        i = 0;
        while (!hif.done && i < bound) begin
            i++;
            @(negedge pixclk);
        end
        t_done = cyc;
        if (!hif.done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
        end
        @(negedge pixclk);
    endtask

    // Keyboard side: clocks 11 pulses, samples data on rising edges,
    // optionally acks on the 11th clock, glitches or stops early.
    task automatic device_xfer(input bit ack, input int abort_k, input int glitch_k,
                               output logic [9:0] rx, output logic sb, output bit aborted);
        aborted = 1'b0;
        rx      = '0;
        sb      = ps2d_w;
        repeat (10) @(negedge pixclk);
        for (int k = 0; k < 11; k++) begin
            if (k == 10 && ack) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            repeat (H) @(negedge pixclk);
            if (k == abort_k) begin
                aborted = 1'b1;
                return;
            end
            dev_c_low = 1'b0;
            if (k < 10) rx[k] = ps2d_w;
            if (k == 10) begin
                dev_d_low = 1'b0;
            end else if (k == glitch_k) begin
                repeat (10) @(negedge pixclk);
                dev_c_low = 1'b1;
                repeat (2) @(negedge pixclk);
                dev_c_low = 1'b0;
                repeat (H - 12) @(negedge pixclk);
            end else begin
                repeat (H) @(negedge pixclk);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input bit dup,
                        input int abort_k, input int glitch_k,
                        input bit lit_en, input logic [9:0] lit);
        int          n_c, n_both, t_done;
        logic [9:0]  rx;
        logic        sb;
        bit          aborted;
        @(negedge pixclk);
        hif.wr   = 1'b1;
        hif.data = d;
        exp_q.push_back(ack ? 1'b0 : 1'b1);
        @(negedge pixclk);
        hif.wr   = 1'b0;
        hif.data = 8'($urandom_range(0, 255));
        check("busy_after_wr", hif.busy, 1);
        n_c = 0;
        while (ps2c_low && !ps2d_low && n_c < 4000) begin
            n_c++;
            if (dup && n_c == 10) begin
                hif.wr   = 1'b1;
                hif.data = ~d;
            end
            if (dup && n_c == 11) hif.wr = 1'b0;
            @(negedge pixclk);
        end
        check("inhibit_len", n_c, INH);
        n_both = 0;
        while (ps2c_low && ps2d_low && n_both < 10) begin
            n_both++;
            @(negedge pixclk);
        end
        check("rts_overlap", n_both, 1);
        device_xfer(ack, abort_k, glitch_k, rx, sb, aborted);
        if (!aborted) begin
            check("start_bit", sb, 0);
            check("frame", rx, model_frame(d));
            if (lit_en) check("frame_literal", rx, lit);
            wait_done(500, t_done);
        end
    endtask

    // ---------------- stimulus ----------------
    int         t0, t1, guard;
    logic [7:0] rd;
    bit         ra;

    initial begin
        rst_n     = 1'b0;
        hif.wr    = 1'b0;
        hif.data  = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        cyc       = 0;
        repeat (4) @(negedge pixclk);
        check("rst_ps2c_low", ps2c_low, 0);
        check("rst_ps2d_low", ps2d_low, 0);
        check("rst_busy", hif.busy, 0);
        check("rst_done", hif.done, 0);
        check("rst_err", hif.err, 0);
        check("rst_state", hif.state, ST_IDLE);
        rst_n = 1'b1;
        repeat (20) @(negedge pixclk);

        // Set-LEDs command with ack, then 0xF4 with ack.
        send(8'hED, 1'b1, 1'b0, -1, -1, 1'b1, 10'h3ED);
        send(8'hF4, 1'b1, 1'b0, -1, -1, 1'b1, 10'h2F4);

        // Device does not ack.
        send(8'hFF, 1'b0, 1'b0, -1, -1, 1'b0, 10'h000);

        // Second wr during inhibit must be ignored.
        send(8'hA5, 1'b1, 1'b1, -1, -1, 1'b0, 10'h000);

        // Short clock glitch must not advance the bit index.
        send(8'hC3, 1'b1, 1'b0, -1, 2, 1'b0, 10'h000);

        // Device never clocks: timeout.
        @(negedge pixclk);
        hif.wr   = 1'b1;
        hif.data = 8'h3C;
        exp_q.push_back(1'b1);
        @(negedge pixclk);
        hif.wr = 1'b0;
        guard = 0;
        while (ps2c_low && guard < 1000) begin
            guard++;
            @(negedge pixclk);
        end
        t0 = cyc;
        wait_done(TO + 100, t1);
        check("timeout_latency", t1 - t0, TO + 1);
        check("timeout_ps2d_released", ps2d_low, 0);
        check("timeout_busy", hif.busy, 0);

        // Reset in the middle of the data bits.
        send(8'h6A, 1'b1, 1'b0, 4, -1, 1'b0, 10'h000);
        check("pre_reset_ps2d_low", ps2d_low, 1);
        check("pre_reset_busy", hif.busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_ps2c_low", ps2c_low, 0);
        check("reset_ps2d_low", ps2d_low, 0);
        check("reset_busy", hif.busy, 0);
        exp_q.delete();
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (3) @(negedge pixclk);
        rst_n = 1'b1;
        repeat (20) @(negedge pixclk);
        send(8'h5B, 1'b1, 1'b0, -1, -1, 1'b0, 10'h000);

        // Random bytes with random ack/NACK.
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) != 0);
            send(rd, ra, 1'b0, -1, -1, 1'b0, 10'h000);
            repeat ($urandom_range(1, 30)) @(negedge pixclk);
        end

        repeat (50) @(negedge pixclk);
        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
